// File: rtl/host_cycle_seq.sv
// Sequences one CPU access onto the BBC host bus. It aligns the access to host phi0 cycles,
// stretches slow accesses, and aborts through a watchdog when phi0 stops toggling.
module host_cycle_seq #(
    parameter int SYNC_STAGES = 2,
    parameter int SLOW_CYCLES = 2,
    parameter int TIMEOUT_W   = 8
) (
    input  logic hsclk,
    input  logic resetb,
    input  logic bbc_phi0,
    input  logic req,
    input  logic slow,
    input  logic rnw,
    output logic lat_en,
    output logic cpu_rdy,
    output logic bbc_rnw,
    output logic bbc_dwe,
    output logic done,
    output logic timeout_err
);
    localparam int CNT_W = (SLOW_CYCLES < 2) ? 1 : $clog2(SLOW_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_SLOW = CNT_W'(SLOW_CYCLES);
    // The watchdog trips on the cycle its count would reach all-ones.
    localparam logic [TIMEOUT_W-1:0] WD_PRE = TIMEOUT_W'((1 << TIMEOUT_W) - 2);

    typedef enum logic [2:0] {IDLE, WAIT_START, PH1, PH2, DONE} state_t;

    state_t                 state_reg;
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   phi0_prev_reg;
    logic                   rnw_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic [TIMEOUT_W-1:0]   wd_reg;

    logic phi0_last;
    logic fall;
    logic rise;
    logic wd_term;

    assign phi0_last = sync_reg[SYNC_STAGES-1];
    assign fall      = phi0_prev_reg & ~phi0_last;
    assign rise      = ~phi0_prev_reg & phi0_last;
    assign wd_term   = (wd_reg == WD_PRE);

    always_ff @(posedge hsclk) begin
        if (!resetb) begin
            sync_reg      <= '0;
            phi0_prev_reg <= 1'b0;
        end else begin
            sync_reg      <= {sync_reg[SYNC_STAGES-2:0], bbc_phi0};
            phi0_prev_reg <= phi0_last;
        end
    end

    always_ff @(posedge hsclk) begin
        if (!resetb) begin
            state_reg   <= IDLE;
            rnw_reg     <= 1'b1;
            cnt_reg     <= '0;
            wd_reg      <= '0;
            lat_en      <= 1'b0;
            cpu_rdy     <= 1'b1;
            bbc_rnw     <= 1'b1;
            bbc_dwe     <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            lat_en <= 1'b0;
            done   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req) begin
                        rnw_reg     <= rnw;
                        cnt_reg     <= slow ? CNT_SLOW : CNT_ONE;
                        wd_reg      <= '0;
                        timeout_err <= 1'b0;
                        lat_en      <= 1'b1;
                        cpu_rdy     <= 1'b0;
                        bbc_rnw     <= rnw;
                        state_reg   <= WAIT_START;
                    end
                end
                WAIT_START, PH1, PH2: begin
                    // A detected edge always wins over the watchdog terminal count.
                    if (fall || rise) begin
                        wd_reg <= '0;
                        if (state_reg == WAIT_START && fall) begin
                            state_reg <= PH1;
                        end else if (state_reg == PH1 && rise) begin
                            state_reg <= PH2;
                            bbc_dwe   <= ~rnw_reg;
                        end else if (state_reg == PH2 && fall) begin
                            bbc_dwe <= 1'b0;
                            if (cnt_reg <= CNT_ONE) begin
                                state_reg <= DONE;
                                done      <= 1'b1;
                                cpu_rdy   <= 1'b1;
                                bbc_rnw   <= 1'b1;
                            end else begin
                                cnt_reg   <= cnt_reg - CNT_ONE;
                                state_reg <= PH1;
                            end
                        end
                    end else if (wd_term) begin
                        wd_reg      <= wd_reg + 1'b1;
                        timeout_err <= 1'b1;
                        state_reg   <= DONE;
                        done        <= 1'b1;
                        cpu_rdy     <= 1'b1;
                        bbc_rnw     <= 1'b1;
                        bbc_dwe     <= 1'b0;
                    end else begin
                        wd_reg <= wd_reg + 1'b1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_host_cycle_seq.sv
// Directed and randomized accesses against a schedule model built from the planned phi0 waveform.
// Outputs are compared every cycle as the vector {lat_en, cpu_rdy, bbc_rnw, bbc_dwe, done, timeout_err}.
module tb_host_cycle_seq;
    localparam int S        = 2;
    localparam int SC       = 2;
    localparam int TW       = 4;
    localparam int WD_LIMIT = (1 << TW) - 1;
    localparam int NPH      = 8192;

    logic hsclk    = 1'b0;
    logic resetb   = 1'b0;
    logic bbc_phi0 = 1'b0;
    logic req      = 1'b0;
    logic slow     = 1'b0;
    logic rnw      = 1'b0;
    logic lat_en, cpu_rdy, bbc_rnw, bbc_dwe, done, timeout_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int ph2_first;
    bit terr_model = 1'b0;
    // Level of phi0 as sampled at each hsclk edge (zeroed where reset cleared the synchroniser).
    bit ph [NPH];
    logic [5:0] exp_q [$];

    host_cycle_seq #(.SYNC_STAGES(S), .SLOW_CYCLES(SC), .TIMEOUT_W(TW)) dut (
        .hsclk(hsclk), .resetb(resetb), .bbc_phi0(bbc_phi0),
        .req(req), .slow(slow), .rnw(rnw),
        .lat_en(lat_en), .cpu_rdy(cpu_rdy), .bbc_rnw(bbc_rnw),
        .bbc_dwe(bbc_dwe), .done(done), .timeout_err(timeout_err)
    );

    always #5 hsclk = ~hsclk;

    function automatic logic [5:0] dut_vec();
        return {lat_en, cpu_rdy, bbc_rnw, bbc_dwe, done, timeout_err};
    endfunction

    task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b (lat,rdy,rnw,dwe,done,terr)", tag, obs, expv);
        end
    endtask

    task automatic step();
        if (cyc >= NPH - 64) begin
            $display("FAIL cycle_budget: observed=%0d required<%0d", cyc, NPH - 64);
            $fatal(1, "cycle budget exhausted");
        end
        bbc_phi0 = ph[cyc];
        @(posedge hsclk);
        #1;
        cyc++;
    endtask

    // Edge acted on by the sequencer at edge j: a phi0 change becomes visible S+1 edges later.
    function automatic int seen(input int j);
        if (j - 1 - S < 0) return 0;
        if (ph[j-1-S] && !ph[j-S]) return -1;
        if (!ph[j-1-S] && ph[j-S]) return 1;
        return 0;
    endfunction

    task automatic fill_const(input int from, input int len, input bit lvl);
        for (int i = from; i < from + len && i < NPH; i++) ph[i] = lvl;
    endtask

    task automatic fill_wave(input int from, input int len, input int lo_h, input int hi_h);
        bit lvl;
        int i;
        int h;
        lvl = !ph[from-1];
        i = from;
        while (i < from + len && i < NPH) begin
            h = $urandom_range(hi_h, lo_h);
            for (int t = 0; t < h && i < NPH; t++) begin
                ph[i] = lvl;
                i++;
            end
            lvl = !lvl;
        end
    endtask

    // Expected output vector for every edge of an access accepted at edge a, through DONE and back to IDLE.
    task automatic plan(input int a, input bit sl, input bit rw);
        int rem;
        int phase;
        int last;
        int j;
        int e;
        bit in_ph2;
        bit abort;
        rem = sl ? SC : 1;
        phase = 0;
        last = a;
        j = a;
        in_ph2 = 1'b0;
        abort = 1'b0;
        ph2_first = -1;
        exp_q.delete();
        exp_q.push_back({1'b1, 1'b0, rw, 1'b0, 1'b0, 1'b0});
        while (1) begin
            j++;
            e = seen(j);
            if (e != 0) begin
                last = j;
                if (phase == 0 && e < 0) begin
                    phase = 1;
                end else if (phase == 1 && e > 0) begin
                    phase = 2;
                    in_ph2 = 1'b1;
                    if (ph2_first < 0) ph2_first = j - a;
                end else if (phase == 2 && e < 0) begin
                    in_ph2 = 1'b0;
                    rem--;
                    if (rem == 0) break;
                    phase = 1;
                end
            end else if (j - last == WD_LIMIT) begin
                abort = 1'b1;
                break;
            end
            exp_q.push_back({1'b0, 1'b0, rw, in_ph2 & ~rw, 1'b0, 1'b0});
        end
        terr_model = abort;
        exp_q.push_back({1'b0, 1'b1, 1'b1, 1'b0, 1'b1, abort});
        exp_q.push_back({1'b0, 1'b1, 1'b1, 1'b0, 1'b0, abort});
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            step();
            check("idle", dut_vec(), {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, terr_model});
        end
    endtask

    task automatic run_access(input string name, input bit sl, input bit rw, input bit hold, input bit mid_req);
        int n;
        req = 1'b1;
        slow = sl;
        rnw = rw;
        plan(cyc, sl, rw);
        n = exp_q.size();
        for (int k = 0; k < n; k++) begin
            if (k == 1) begin
                req  = hold;
                slow = 1'($urandom_range(1, 0));
                rnw  = 1'($urandom_range(1, 0));
            end
            if (mid_req && k == n / 2) req = 1'b1;
            step();
            check($sformatf("%s+%0d", name, k), dut_vec(), exp_q[k]);
            if (exp_q[k][1] && !hold) req = 1'b0;
        end
    endtask

    task automatic reset_in_ph2();
        int r;
        req = 1'b1;
        slow = 1'b0;
        rnw = 1'b0;
        plan(cyc, 1'b0, 1'b0);
        for (int k = 0; k <= ph2_first; k++) begin
            if (k == 1) req = 1'b0;
            step();
            check($sformatf("rst_wr+%0d", k), dut_vec(), exp_q[k]);
        end
        resetb = 1'b0;
        step();
        check("rst_mid", dut_vec(), 6'b011000);
        resetb = 1'b1;
        r = cyc - 1;
        for (int i = r - S; i <= r; i++) ph[i] = 1'b0;
        terr_model = 1'b0;
        idle(6);
    endtask

    initial begin
        fill_const(0, 40, 1'b0);
        repeat (3) step();
        check("reset", dut_vec(), 6'b011000);
        resetb = 1'b1;
        idle(3);

        fill_wave(cyc, 200, 4, 4);
        run_access("fast_wr", 1'b0, 1'b0, 1'b0, 1'b0);
        idle(2);
        run_access("slow_rd", 1'b1, 1'b1, 1'b0, 1'b0);
        idle(2);

        // phi0 stalled low: watchdog abort, sticky error, cleared by the next acceptance
        fill_const(cyc, 60, 1'b0);
        idle(6);
        run_access("timeout", 1'b0, 1'b1, 1'b0, 1'b0);
        idle(3);
        fill_wave(cyc, 3000, 2, 7);
        run_access("clear_terr", 1'b0, 1'b0, 1'b0, 1'b0);

        run_access("held1", 1'b0, 1'b1, 1'b1, 1'b0);
        run_access("held2", 1'b1, 1'b0, 1'b0, 1'b1);
        idle(2);
        reset_in_ph2();

        // PH2 lasting exactly the watchdog span: the fall wins; one cycle longer: abort from PH2
        fill_const(cyc, 10, 1'b0);
        idle(6);
        fill_const(cyc, 3, 1'b0);
        fill_const(cyc + 3, 4, 1'b1);
        fill_const(cyc + 7, 4, 1'b0);
        fill_const(cyc + 11, WD_LIMIT, 1'b1);
        fill_const(cyc + 11 + WD_LIMIT, 40, 1'b0);
        run_access("wd_edge", 1'b0, 1'b0, 1'b0, 1'b0);
        idle(8);
        fill_const(cyc, 3, 1'b0);
        fill_const(cyc + 3, 4, 1'b1);
        fill_const(cyc + 7, 4, 1'b0);
        fill_const(cyc + 11, WD_LIMIT + 1, 1'b1);
        fill_const(cyc + 12 + WD_LIMIT, 40, 1'b0);
        run_access("wd_ph2", 1'b0, 1'b0, 1'b0, 1'b0);
        idle(8);

        fill_wave(cyc, 3000, 2, 7);
        for (int i = 0; i < 12; i++) begin
            run_access($sformatf("rnd%0d", i), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                       1'b0, 1'($urandom_range(1, 0)));
            idle($urandom_range(3, 1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/host_cycle_seq.md
Name: host_cycle_seq

Overview:
Sequences CPU accesses that must run on the BBC host bus, in the fast (hsclk) domain of the accelerator CPLD. Accepts a request from the CPU-side decoder and pulses the host address latch enable. Stalls the CPU via cpu_rdy, aligns the access to host phi0 cycles, and stretches slow (1MHz/FE4x/FC/FD) accesses over multiple host cycles. A watchdog aborts the access if host phi0 stops.

Parameters:
SYNC_STAGES, 2, number of flops in bbc_phi0 synchroniser (min 2)
SLOW_CYCLES, 2, host phi0 cycles consumed by a slow access (min 1; fast accesses always take 1)
TIMEOUT_W, 8, width of watchdog counter; abort at count 2^TIMEOUT_W-1

Ports:
hsclk  input  1  single system clock (fast CPU-side clock)
resetb  input  1  synchronous active-low reset, sampled on hsclk rising edge
bbc_phi0  input  1  host 2MHz phi0, asynchronous to hsclk
req  input  1  level request for a host access; sampled only in IDLE
slow  input  1  access needs 1MHz stretching (from dec_fe4x); captured with req
rnw  input  1  CPU read-not-write; captured with req
lat_en  output  1  one-cycle pulse loading CPU address into host address latch
cpu_rdy  output  1  high = CPU may proceed; low while a host access is in flight
bbc_rnw  output  1  captured rnw driven to host; 1 when idle
bbc_dwe  output  1  host data bus drive enable; write accesses, phase 2 only
done  output  1  one-cycle pulse at end of access (normal or aborted)
timeout_err  output  1  sticky: last access aborted by watchdog

Behaviour:
- Reset values (resetb=0 at a clock edge): state IDLE; lat_en=0, cpu_rdy=1, bbc_rnw=1, bbc_dwe=0, done=0, timeout_err=0; synchroniser flops, cycle counter and watchdog all 0.
- phi0 sync: SYNC_STAGES-flop chain; fall = prev_stage & ~last_stage, rise = ~prev_stage & last_stage, computed from last two registered samples.
- All outputs are registered.
- States: IDLE, WAIT_START, PH1, PH2, DONE.
- IDLE: on req=1, capture slow/rnw, load cycle counter with SLOW_CYCLES (slow=1) or 1 (slow=0), clear timeout_err and watchdog, go to WAIT_START. On the next cycle lat_en=1 (exactly one cycle), cpu_rdy=0, and bbc_rnw=captured rnw.
- WAIT_START: on fall go to PH1. This aligns the access start to the beginning of a host cycle; a rise in this state is ignored.
- PH1 (phi0 low): on rise go to PH2.
- PH2 (phi0 high): bbc_dwe=~captured rnw. On fall: if counter==1 go to DONE, else decrement and go to PH1.
- DONE: single cycle. done=1, cpu_rdy=1, bbc_dwe=0, bbc_rnw=1; then go to IDLE unconditionally. req is ignored in DONE.
- Requester protocol: drop req in the cycle done is seen. If req is still high in IDLE it is taken as a new request.
- cpu_rdy low from the cycle after acceptance up to, but not including, the DONE cycle.
- Watchdog: cleared on acceptance and on every detected rise or fall. Increments each cycle in WAIT_START, PH1 and PH2. On reaching 2^TIMEOUT_W-1, set timeout_err and go to DONE.
- An edge in the same cycle as the watchdog terminal count takes priority: the edge transition is taken and the watchdog clears.
- Counter is never decremented below 1.
- Nominal latency, req to done, fast access: lat_en +1, plus wait to the next phi0 fall (sync delay SYNC_STAGES+1), plus one full phi0 cycle, plus 1. Slow access adds (SLOW_CYCLES-1) phi0 cycles.
- Reset mid-access: returns to IDLE in the same edge, with all reset values. No done pulse is generated.
- An in-flight access is abandoned. The requester must re-issue it.

Test Plan:
- Fast write, phi0 = hsclk/8 (4 low/4 high), req=1 slow=0 rnw=0: lat_en single pulse one cycle after req; cpu_rdy low; bbc_dwe=1 for the 4 PH2 cycles only; done after exactly one full phi0 cycle from the first synchronised fall; timeout_err=0.
- Slow read, SLOW_CYCLES=2, rnw=1: bbc_rnw=1 throughout; bbc_dwe never asserted; cpu_rdy low across two phi0 falls in PH2; done one cycle after the second PH2 fall.
- phi0 held low after acceptance, TIMEOUT_W=4: after 15 cycles without an edge, done pulses and timeout_err=1 (stays 1). The next accepted req clears it.
- req held high through done: one idle cycle after DONE, then a second access is accepted with a new lat_en pulse. req raised during PH1: no effect on the current access.
- resetb=0 asserted in PH2 of a write: the next cycle shows cpu_rdy=1, bbc_dwe=0, bbc_rnw=1, done=0, state IDLE.
- Force the watchdog to terminal count in the same cycle as a synchronised fall in PH2 (counter=1): DONE is entered via the normal path, and timeout_err remains 0.
